// File: rtl/form_equiv_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : form_equiv_sequencer
// Description : Exhaustive equivalence sweep over three evaluators of the same
//               4-input Boolean function (canonical, POS, SOP). Each of the 16
//               input vectors is driven on abcd and held for SETTLE_CYCLES
//               cycles. The three responses are then sampled for one cycle.
//               The block tallies mismatching vectors and records the first
//               failing index and the canonical truth table.
//
// Parameters  : SETTLE_CYCLES  hold cycles per vector before sampling (1..15)
//
// Ports       : clk               clock, all state on the rising edge
//               rst_n             asynchronous active-low reset
//               start             sweep request, accepted only in IDLE
//               abort             synchronous sweep cancel
//               abcd[3:0]         vector to the evaluators, {A,B,C,D}
//               out_a/out_b/out_c canonical / POS / SOP responses
//               busy              high in SETTLE and SAMPLE
//               done              one-cycle pulse while in DONE
//               pass              last completed sweep had no mismatches
//               mismatch_cnt[4:0] number of mismatching vectors (0..16)
//               first_fail_idx    index of the first mismatching vector
//               first_fail_valid  first_fail_idx is meaningful
//               truth_table[15:0] bit i = out_a sampled at vector i
//
// Build macro : FORM_EQUIV_HALT_ON_FAIL_EN - stop the sweep at the first
//               mismatching vector (idx held at the failing index).
//
// Revision    : 1.0 - initial release
// ============================================================================
module form_equiv_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  abcd,
  input  logic        out_a,
  input  logic        out_b,
  input  logic        out_c,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail_idx,
  output logic        first_fail_valid,
  output logic [15:0] truth_table
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // The settle counter counts down to zero, so it is loaded with N-1 to
  // give exactly N cycles in SETTLE.
  localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [3:0]  r_settle;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [4:0]  r_cnt;
  logic [3:0]  r_ffi;
  logic        r_ffv;
  logic [15:0] r_tt;

  logic        w_mis;
  logic [4:0]  w_cnt_inc;
  logic        w_pass_final;

  // A vector mismatches when the three evaluators do not all agree.
  assign w_mis        = (out_a != out_b) || (out_a != out_c);
  assign w_cnt_inc    = r_cnt + 5'd1;
  // Pass verdict must include the vector being sampled in this cycle.
  assign w_pass_final = (r_cnt == 5'd0) && !w_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= 4'd0;
      r_settle <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_cnt    <= 5'd0;
      r_ffi    <= 4'd0;
      r_ffv    <= 1'b0;
      r_tt     <= 16'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // abort has priority over a simultaneous start
          if (start && !abort) begin
            r_idx    <= 4'd0;
            r_cnt    <= 5'd0;
            r_ffv    <= 1'b0;
            r_pass   <= 1'b0;
            r_tt     <= 16'd0;
            r_settle <= c_settle_load;
            r_busy   <= 1'b1;
            r_state  <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_idx   <= 4'd0;
          end else if (r_settle == 4'd0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end

        S_SAMPLE: begin
          if (abort) begin
            // Cancelled sample is discarded; earlier results are kept.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_idx   <= 4'd0;
          end else begin
            r_tt[r_idx] <= out_a;
            if (w_mis) begin
              r_cnt <= w_cnt_inc;
              if (!r_ffv) begin
                r_ffi <= r_idx;
                r_ffv <= 1'b1;
              end
            end
`ifdef FORM_EQUIV_HALT_ON_FAIL_EN
            if (w_mis) begin
              // Halt on the first failure: idx stays on the failing vector.
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= 1'b0;
            end else
`endif
            if (r_idx == 4'd15) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= w_pass_final;
            end else begin
              r_idx    <= r_idx + 4'd1;
              r_settle <= c_settle_load;
              r_state  <= S_SETTLE;
            end
          end
        end

        S_DONE: begin
          // Results and idx hold until the next accepted start.
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign abcd             = r_idx;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign mismatch_cnt     = r_cnt;
  assign first_fail_idx   = r_ffi;
  assign first_fail_valid = r_ffv;
  assign truth_table      = r_tt;

endmodule
`default_nettype wire

// File: doc/form_equiv_sequencer.md
FORM_EQUIV_SEQUENCER -- requirements
Module: form_equiv_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1: cycles each input vector is held before sampling, legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: sweep request, sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: synchronous sweep cancel.
REQ-006 The block SHALL have port abcd, output, 4 bits: vector driven to all three form evaluators, {A,B,C,D} with A as MSB.
REQ-007 The block SHALL have ports out_a, out_b and out_c, input, 1 bit each: responses of the canonical, POS and SOP evaluators.
REQ-008 The block SHALL have port busy, output, 1 bit: high in SETTLE and SAMPLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse on sweep completion.
REQ-010 The block SHALL have port pass, output, 1 bit: high when the last completed sweep had zero mismatches.
REQ-011 The block SHALL have port mismatch_cnt, output, 5 bits: mismatching vectors, 0..16.
REQ-012 The block SHALL have port first_fail_idx, output, 4 bits: index of the first mismatching vector.
REQ-013 The block SHALL have port first_fail_valid, output, 1 bit: first_fail_idx is meaningful.
REQ-014 The block SHALL have port truth_table, output, 16 bits: bit i holds out_a sampled at vector i.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-016 In IDLE, start=1 with abort=0 SHALL clear idx, mismatch_cnt, first_fail_valid, pass and truth_table, load the settle counter, and enter SETTLE.
REQ-017 abcd SHALL equal idx at all times; idx SHALL be 0 in IDLE after reset.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-019 SAMPLE SHALL last one cycle: truth_table[idx] <= out_a; a mismatch (out_a, out_b, out_c not all equal) SHALL increment mismatch_cnt, and the first mismatch of the sweep SHALL set first_fail_idx=idx and first_fail_valid=1.
REQ-020 From SAMPLE, if idx=15 the FSM SHALL enter DONE; otherwise idx SHALL increment, the settle counter SHALL reload, and the FSM SHALL enter SETTLE. idx SHALL NOT wrap within a sweep.
REQ-021 A sweep SHALL take 16*(SETTLE_CYCLES+1) cycles in SETTLE/SAMPLE; done SHALL be high in the single DONE cycle, after which the FSM SHALL return to IDLE.
REQ-022 pass SHALL be set to (mismatch_cnt==0) on entry to DONE. All result outputs SHALL hold until the next accepted start.
REQ-023 start SHALL be ignored while busy or in DONE.
REQ-024 abort=1 in SETTLE or SAMPLE SHALL force IDLE on the next edge: no done pulse, pass=0, partial counts held, idx=0.
REQ-025 abort=1 together with start=1 in IDLE SHALL take priority: the FSM SHALL stay in IDLE.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, idx=0, abcd=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_idx=0, first_fail_valid=0 and truth_table=0, including mid-sweep.
REQ-027 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-028 With macro FORM_EQUIV_HALT_ON_FAIL_EN defined, the first mismatch in SAMPLE SHALL go directly to DONE with idx held at the failing index, mismatch_cnt=1 and pass=0.
REQ-029 Without FORM_EQUIV_HALT_ON_FAIL_EN, the block SHALL always sweep all 16 vectors.

Verification
REQ-030 The bench SHALL check: SETTLE_CYCLES=1, out_a=out_b=out_c=A^D, start pulse -> done 33 cycles after the start-accept edge, pass=1, mismatch_cnt=0, first_fail_valid=0, truth_table=16'h55AA.
REQ-031 The bench SHALL check: same, but out_c inverted at idx 5 and 9 -> mismatch_cnt=2, first_fail_idx=5, first_fail_valid=1, pass=0.
REQ-032 The bench SHALL check: abort pulse 10 cycles into a sweep -> busy=0 next cycle, done never pulses, pass=0, idx=0.
REQ-033 The bench SHALL check: start while busy has no effect on timing; start+abort together in IDLE -> busy stays 0.
REQ-034 The bench SHALL check: rst_n low mid-sweep at idx 7 -> all outputs 0 asynchronously, then a new start gives a full 33-cycle sweep.
REQ-035 The bench SHALL check: with FORM_EQUIV_HALT_ON_FAIL_EN and a mismatch at idx 5, SETTLE_CYCLES=1 -> done 13 cycles after start accept, mismatch_cnt=1, abcd=5.
